lstm_feeder: RTL and testbench

Front-end sequencer that drives the LSTM cell's load/next/done interface. It accepts per-event input records (PID, mode, 512-bit data) on a valid/ready stream. It keeps a small per-PID context table of Ct/Ht, restores the matching context into the LSTM before each step, and writes back the updated Ct/Ht when the step completes. It also emits Ht per event to the downstream anomaly scorer.

---
 rtl/lstm_pkg.sv | 20 ++
 rtl/lstm_ctx_table.sv | 51 +++++
 rtl/lstm_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_lstm_feeder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM front end and cell: mode codes, datapath width
// and the feeder state encoding.
package lstm_pkg;

    localparam int   DATA_W   = 512;
    localparam logic SYS_TYPE = 1'b0;
    localparam logic BR_TYPE  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_WRITEBACK,
        ST_ERROR
    } feeder_state_e;

endpackage

// File: rtl/lstm_ctx_table.sv
// Direct-mapped Ct/Ht context table: combinational read by index, one synchronous
// write port. Only the valid bits are reset.
module lstm_ctx_table
    import lstm_pkg::*;
#(
    parameter int PID_W   = 10,
    parameter int ENTRIES = 4,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [PID_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_ct_o,
    output logic [DATA_W-1:0] rd_ht_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [PID_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_ct_i,
    input  logic [DATA_W-1:0] wr_ht_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [PID_W-1:0]   tag_q [ENTRIES];
    logic [DATA_W-1:0]  ct_q  [ENTRIES];
    logic [DATA_W-1:0]  ht_q  [ENTRIES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: payload arrays carry no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            ct_q[wr_idx_i]  <= wr_ct_i;
            ht_q[wr_idx_i]  <= wr_ht_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_ct_o    = ct_q[rd_idx_i];
    assign rd_ht_o    = ht_q[rd_idx_i];

endmodule

// File: rtl/lstm_feeder.sv
// Sequencer that restores per-PID Ct/Ht into the LSTM, issues a step and writes the result back.
// Define LSTM_FEEDER_WDOG_EN to add the wait-state watchdog and terminal ERROR state.
module lstm_feeder
    import lstm_pkg::*;
#(
    parameter int PID_bit     = 10,
    parameter int CTX_ENTRIES = 4,
    parameter int WDOG_LIMIT  = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iRec_valid,
    output logic               oRec_ready,
    input  logic [PID_bit-1:0] iRec_pid,
    input  logic               iRec_mode,
    input  logic [DATA_W-1:0]  iRec_data,
    output logic               oLoad_valid,
    output logic [DATA_W-1:0]  oCt_load,
    output logic [DATA_W-1:0]  oHt_load,
    output logic               oNext_valid,
    output logic               oMode,
    output logic [DATA_W-1:0]  oData,
    input  logic               iLstm_done,
    input  logic [DATA_W-1:0]  iCt,
    input  logic [DATA_W-1:0]  iHt,
    output logic               oResult_valid,
    output logic [PID_bit-1:0] oResult_pid,
    output logic [DATA_W-1:0]  oResult_ht,
    output logic               oError
);

    localparam int IDX_W = $clog2(CTX_ENTRIES);

    feeder_state_e      state_q, state_d;
    logic [PID_bit-1:0] pid_q, pid_d, last_pid_q, last_pid_d, res_pid_q, res_pid_d;
    logic               mode_q, mode_d, omode_q, omode_d;
    logic               last_valid_q, last_valid_d;
    logic               load_valid_q, load_valid_d, next_valid_q, next_valid_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  data_q, data_d, odata_q, odata_d;
    logic [DATA_W-1:0]  ct_load_q, ct_load_d, ht_load_q, ht_load_d, res_ht_q, res_ht_d;

    logic               tbl_valid, tbl_we, hit;
    logic [PID_bit-1:0] tbl_tag;
    logic [DATA_W-1:0]  tbl_ct, tbl_ht;

    lstm_ctx_table #(.PID_W(PID_bit), .ENTRIES(CTX_ENTRIES)) u_ctx_table (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (pid_q[IDX_W-1:0]),
        .rd_valid_o (tbl_valid),
        .rd_tag_o   (tbl_tag),
        .rd_ct_o    (tbl_ct),
        .rd_ht_o    (tbl_ht),
        .wr_en_i    (tbl_we),
        .wr_idx_i   (pid_q[IDX_W-1:0]),
        .wr_tag_i   (pid_q),
        .wr_ct_i    (iCt),
        .wr_ht_i    (iHt)
    );

    assign hit        = tbl_valid && (tbl_tag == pid_q);
    assign oRec_ready = (state_q == ST_IDLE) && iLstm_done;

`ifdef LSTM_FEEDER_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              error_q, error_d;
    assign oError = error_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_LIMIT;
    assign oError      = 1'b0;
`endif

    // NOTE: every signal gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        mode_d       = mode_q;
        data_d       = data_q;
        last_pid_d   = last_pid_q;
        last_valid_d = last_valid_q;
        ct_load_d    = ct_load_q;
        ht_load_d    = ht_load_q;
        omode_d      = omode_q;
        odata_d      = odata_q;
        res_pid_d    = res_pid_q;
        res_ht_d     = res_ht_q;
        load_valid_d = 1'b0;
        next_valid_d = 1'b0;
        res_valid_d  = 1'b0;
        tbl_we       = 1'b0;
`ifdef LSTM_FEEDER_WDOG_EN
        wdog_d       = wdog_q;
        error_d      = error_q;
`endif
        case (state_q)
            ST_IDLE: if (iRec_valid && oRec_ready) begin
                pid_d   = iRec_pid;
                mode_d  = iRec_mode;
                data_d  = iRec_data;
                state_d = ST_LOOKUP;
            end
            ST_LOOKUP: if (last_valid_q && last_pid_q == pid_q) begin
                // The LSTM still holds this PID's context from its previous step.
                state_d      = ST_ISSUE;
                next_valid_d = 1'b1;
                omode_d      = mode_q;
                odata_d      = data_q;
            end else begin
                state_d      = ST_LOAD;
                load_valid_d = 1'b1;
                ct_load_d    = hit ? tbl_ct : '0;
                ht_load_d    = hit ? tbl_ht : '0;
            end
            ST_LOAD: begin
                state_d      = ST_ISSUE;
                next_valid_d = 1'b1;
                omode_d      = mode_q;
                odata_d      = data_q;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
`ifdef LSTM_FEEDER_WDOG_EN
                wdog_d  = '0;
`endif
            end
            ST_WAIT_BUSY: if (!iLstm_done) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (iLstm_done) begin
                state_d      = ST_WRITEBACK;
                tbl_we       = 1'b1;
                res_valid_d  = 1'b1;
                res_pid_d    = pid_q;
                res_ht_d     = iHt;
                last_pid_d   = pid_q;
                last_valid_d = 1'b1;
            end
            ST_WRITEBACK: state_d = ST_IDLE;
            ST_ERROR:     state_d = ST_ERROR;
            default:      state_d = ST_IDLE;
        endcase
`ifdef LSTM_FEEDER_WDOG_EN
        if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (wdog_d == WDOG_W'(WDOG_LIMIT)) begin
                state_d = ST_ERROR;
                error_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pid_q        <= '0;
            mode_q       <= 1'b0;
            data_q       <= '0;
            last_pid_q   <= '0;
            last_valid_q <= 1'b0;
            load_valid_q <= 1'b0;
            ct_load_q    <= '0;
            ht_load_q    <= '0;
            next_valid_q <= 1'b0;
            omode_q      <= 1'b0;
            odata_q      <= '0;
            res_valid_q  <= 1'b0;
            res_pid_q    <= '0;
            res_ht_q     <= '0;
`ifdef LSTM_FEEDER_WDOG_EN
            wdog_q       <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pid_q        <= pid_d;
            mode_q       <= mode_d;
            data_q       <= data_d;
            last_pid_q   <= last_pid_d;
            last_valid_q <= last_valid_d;
            load_valid_q <= load_valid_d;
            ct_load_q    <= ct_load_d;
            ht_load_q    <= ht_load_d;
            next_valid_q <= next_valid_d;
            omode_q      <= omode_d;
            odata_q      <= odata_d;
            res_valid_q  <= res_valid_d;
            res_pid_q    <= res_pid_d;
            res_ht_q     <= res_ht_d;
`ifdef LSTM_FEEDER_WDOG_EN
            wdog_q       <= wdog_d;
            error_q      <= error_d;
`endif
        end
    end

    assign oLoad_valid   = load_valid_q;
    assign oCt_load      = ct_load_q;
    assign oHt_load      = ht_load_q;
    assign oNext_valid   = next_valid_q;
    assign oMode         = omode_q;
    assign oData         = odata_q;
    assign oResult_valid = res_valid_q;
    assign oResult_pid   = res_pid_q;
    assign oResult_ht    = res_ht_q;

endmodule

// File: tb/tb_lstm_feeder.sv
// Bench for lstm_feeder: directed and random steps checked against a per-PID context model
// and a model LSTM driven from the bench.
module tb_lstm_feeder;
    import lstm_pkg::*;

    localparam int PID_W = 10;
    localparam int ENTR  = 4;
`ifdef LSTM_FEEDER_WDOG_EN
    localparam int WLIM  = 16;
`else
    localparam int WLIM  = 4096;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              iRec_valid = 1'b0, iRec_mode = 1'b0, iLstm_done = 1'b1;
    logic [PID_W-1:0]  iRec_pid = '0;
    logic [DATA_W-1:0] iRec_data = '0, iCt = '0, iHt = '0;
    logic              oRec_ready, oLoad_valid, oNext_valid, oMode, oResult_valid, oError;
    logic [DATA_W-1:0] oCt_load, oHt_load, oData, oResult_ht;
    logic [PID_W-1:0]  oResult_pid;

    lstm_feeder #(.PID_bit(PID_W), .CTX_ENTRIES(ENTR), .WDOG_LIMIT(WLIM)) dut (
        .clk(clk), .reset(reset),
        .iRec_valid(iRec_valid), .oRec_ready(oRec_ready), .iRec_pid(iRec_pid),
        .iRec_mode(iRec_mode), .iRec_data(iRec_data),
        .oLoad_valid(oLoad_valid), .oCt_load(oCt_load), .oHt_load(oHt_load),
        .oNext_valid(oNext_valid), .oMode(oMode), .oData(oData),
        .iLstm_done(iLstm_done), .iCt(iCt), .iHt(iHt),
        .oResult_valid(oResult_valid), .oResult_pid(oResult_pid), .oResult_ht(oResult_ht),
        .oError(oError)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference context: what each PID's last completed step left behind.
    logic              m_valid [ENTR];
    logic [PID_W-1:0]  m_tag   [ENTR];
    logic [DATA_W-1:0] m_ct    [ENTR];
    logic [DATA_W-1:0] m_ht    [ENTR];
    logic              m_last_valid;
    logic [PID_W-1:0]  m_last_pid;
    logic [PID_W-1:0]  cur_pid;
    logic [DATA_W-1:0] cur_data;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand512();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTR; i++) m_valid[i] = 1'b0;
        m_last_valid = 1'b0;
        m_last_pid   = '0;
    endtask

    // Presents a record (optionally with the LSTM busy for hold cycles first), then follows
    // it to the ISSUE cycle, checking restore data, pulse timing and issued payload.
    task automatic start_step(input logic [PID_W-1:0] pid, input logic mode,
                              input logic [DATA_W-1:0] data, input int hold);
        int idx, load_cyc, next_cyc;
        logic skip, hit;
        logic [DATA_W-1:0] exp_ct, exp_ht, seen_ct, seen_ht, seen_data;
        logic seen_mode;
        idx    = int'(pid) % ENTR;
        skip   = m_last_valid && m_last_pid == pid;
        hit    = m_valid[idx] && m_tag[idx] == pid;
        exp_ct = hit ? m_ct[idx] : '0;
        exp_ht = hit ? m_ht[idx] : '0;
        cur_pid  = pid;
        cur_data = data;
        iRec_valid = 1'b1; iRec_pid = pid; iRec_mode = mode; iRec_data = data;
        if (hold > 0) begin
            iLstm_done = 1'b0;
            for (int h = 0; h < hold; h++) begin
                #1;
                check("bp_ready_low", DATA_W'(oRec_ready), '0);
                @(negedge clk);
                check("bp_no_start", DATA_W'(oLoad_valid | oNext_valid), '0);
            end
            iLstm_done = 1'b1;
        end
        #1;
        check("rec_ready", DATA_W'(oRec_ready), DATA_W'(1));
        @(posedge clk);
        #1 iRec_valid = 1'b0;
        load_cyc = 0; next_cyc = 0;
        seen_ct = '0; seen_ht = '0; seen_data = '0; seen_mode = 1'b0;
        for (int k = 1; k <= 8 && next_cyc == 0; k++) begin
            @(negedge clk);
            if (oLoad_valid && oNext_valid) check("load_next_overlap", DATA_W'(1), '0);
            if (oLoad_valid && load_cyc == 0) begin
                load_cyc = k; seen_ct = oCt_load; seen_ht = oHt_load;
            end
            if (oNext_valid) begin
                next_cyc = k; seen_mode = oMode; seen_data = oData;
            end
        end
        check("load_cycle", DATA_W'(load_cyc), skip ? '0 : DATA_W'(2));
        check("next_cycle", DATA_W'(next_cyc), skip ? DATA_W'(2) : DATA_W'(3));
        if (!skip) begin
            check("restore_ct", seen_ct, exp_ct);
            check("restore_ht", seen_ht, exp_ht);
        end
        check("issue_mode", DATA_W'(seen_mode), DATA_W'(mode));
        check("issue_data", seen_data, data);
    endtask

    // Model LSTM: goes busy from the ISSUE cycle, returns ct/ht after busy cycles.
    task automatic finish_step(input logic [DATA_W-1:0] ct, input logic [DATA_W-1:0] ht,
                               input int busy);
        int idx;
        iLstm_done = 1'b0;
        repeat (busy) @(negedge clk);
        check("data_held", oData, cur_data);
        iCt = ct; iHt = ht; iLstm_done = 1'b1;
        @(negedge clk);
        check("result_valid", DATA_W'(oResult_valid), DATA_W'(1));
        check("result_pid", DATA_W'(oResult_pid), DATA_W'(cur_pid));
        check("result_ht", oResult_ht, ht);
        @(negedge clk);
        check("result_pulse_end", DATA_W'(oResult_valid), '0);
        idx = int'(cur_pid) % ENTR;
        m_valid[idx] = 1'b1; m_tag[idx] = cur_pid; m_ct[idx] = ct; m_ht[idx] = ht;
        m_last_valid = 1'b1; m_last_pid = cur_pid;
    endtask

    task automatic step(input logic [PID_W-1:0] pid, input logic mode, input logic [DATA_W-1:0] data,
                        input logic [DATA_W-1:0] ct, input logic [DATA_W-1:0] ht, input int busy);
        start_step(pid, mode, data, 0);
        finish_step(ct, ht, busy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  DATA_W'(oRec_ready), '0);
        check({tag, "_load"},   DATA_W'(oLoad_valid), '0);
        check({tag, "_ct"},     oCt_load, '0);
        check({tag, "_ht"},     oHt_load, '0);
        check({tag, "_next"},   DATA_W'(oNext_valid), '0);
        check({tag, "_mode"},   DATA_W'(oMode), '0);
        check({tag, "_data"},   oData, '0);
        check({tag, "_res"},    DATA_W'(oResult_valid), '0);
        check({tag, "_respid"}, DATA_W'(oResult_pid), '0);
        check({tag, "_resht"},  oResult_ht, '0);
        check({tag, "_err"},    DATA_W'(oError), '0);
    endtask

    logic [DATA_W-1:0] pat_a5, pat_11, pat_22;

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_11 = {64{8'h11}};
        pat_22 = {64{8'h22}};
        model_clear();

        // Reset state (LSTM held busy so the ready output must also be 0).
        iLstm_done = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        iLstm_done = 1'b1;
        @(negedge clk);

        // Cold miss, then a repeat that skips LOAD.
        step(10'd5, SYS_TYPE, pat_a5, pat_22, pat_11, 3);
        step(10'd5, BR_TYPE, rand512(), rand512(), rand512(), 2);

        // Interleave 5/6/5: third step restores 5's stored context.
        step(10'd5, SYS_TYPE, pat_a5, pat_22, pat_11, 2);
        step(10'd6, BR_TYPE, rand512(), rand512(), rand512(), 4);
        start_step(10'd5, SYS_TYPE, rand512(), 0);
        check("interleave_restored_ht", oHt_load, pat_11);
        finish_step(rand512(), rand512(), 2);

        // Collision 1/5/1 on index 1: third step restores zeros.
        step(10'd1, BR_TYPE, rand512(), rand512(), rand512(), 2);
        step(10'd5, SYS_TYPE, rand512(), rand512(), rand512(), 3);
        start_step(10'd1, BR_TYPE, rand512(), 0);
        check("collision_zero_ct", oCt_load, '0);
        finish_step(rand512(), rand512(), 2);

        // Backpressure from a busy LSTM while idle.
        start_step(10'd2, SYS_TYPE, rand512(), 3);
        finish_step(rand512(), rand512(), 2);

        // Reset while waiting for the LSTM: no result, and the context is forgotten.
        start_step(10'd7, BR_TYPE, rand512(), 0);
        iLstm_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        iHt = rand512();
        iLstm_done = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset_no_result", DATA_W'(oResult_valid), '0);
        end
        step(10'd5, SYS_TYPE, rand512(), rand512(), rand512(), 2);

        // Random traffic over a small PID set so hits, skips and collisions all occur.
        for (int n = 0; n < 24; n++) begin
            step(PID_W'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), rand512(),
                 rand512(), rand512(), int'($urandom_range(2, 5)));
        end

`ifdef LSTM_FEEDER_WDOG_EN
        // Watchdog: the LSTM never goes busy, so the step stalls in WAIT_BUSY.
        start_step(10'd3, SYS_TYPE, rand512(), 0);
        repeat (WLIM + 2) @(negedge clk);
        check("wdog_error", DATA_W'(oError), DATA_W'(1));
        check("wdog_not_ready", DATA_W'(oRec_ready), '0);
`else
        check("no_wdog_error", DATA_W'(oError), '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
